// File: rtl/basilisk_macc_scheduler.sv
// Issue/writeback scheduler for the basilisk FMA path: round-robin issue of per-channel
// commands onto one fixed-latency FMA unit, accumulator substitution, and credit-protected result FIFOs.
module basilisk_macc_scheduler #(
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 4,
    parameter int OUT_DEPTH = 4,
    parameter int FLOAT_W   = 32,
    localparam int TAG_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           cmd_valid,
    output logic [CHANNELS-1:0]           cmd_ready,
    input  logic [CHANNELS*FLOAT_W-1:0]   cmd_a,
    input  logic [CHANNELS*FLOAT_W-1:0]   cmd_b,
    input  logic [CHANNELS*FLOAT_W-1:0]   cmd_c,
    input  logic [CHANNELS-1:0]           cmd_use_acc,
    input  logic [CHANNELS*3-1:0]         cmd_mode,
    output logic                          fpu_valid,
    output logic [FLOAT_W-1:0]            fpu_a,
    output logic [FLOAT_W-1:0]            fpu_b,
    output logic [FLOAT_W-1:0]            fpu_c,
    output logic [2:0]                    fpu_mode,
    output logic [TAG_W-1:0]              fpu_tag,
    input  logic                          fpu_result_valid,
    input  logic [FLOAT_W-1:0]            fpu_result,
    output logic [CHANNELS-1:0]           res_valid,
    input  logic [CHANNELS-1:0]           res_ready,
    output logic [CHANNELS*FLOAT_W-1:0]   res_data,
    output logic                          error
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    // Handshakes: a command transfers on cmd_valid[i] & cmd_ready[i]; a result pops on
    // res_valid[i] & res_ready[i]. cmd_ready may depend combinationally on cmd_valid.

    logic [CHANNELS-1:0]         eligible;
    logic [CHANNELS-1:0]         grant;
    logic [TAG_W-1:0]            grant_idx;
    logic                        grant_any;
    logic [TAG_W-1:0]            rr_ptr;
    logic [CHANNELS*FLOAT_W-1:0] chan_c;
    logic [FLOAT_W-1:0]          sel_a;
    logic [FLOAT_W-1:0]          sel_b;
    logic [FLOAT_W-1:0]          sel_c;
    logic [2:0]                  sel_mode;

    logic [LATENCY-1:0]          pipe_valid;
    logic [TAG_W-1:0]            pipe_tag [LATENCY];
    logic                        exp_valid;
    logic [TAG_W-1:0]            exp_tag;
    logic                        ret;

    assign exp_valid = pipe_valid[LATENCY-1];
    assign exp_tag   = pipe_tag[LATENCY-1];
    assign ret       = fpu_result_valid && exp_valid;
    assign cmd_ready = grant;

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(rr_ptr) + k) % CHANNELS;
            if (!grant_any && eligible[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_c    = '0;
        sel_mode = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_a    = cmd_a[i*FLOAT_W +: FLOAT_W];
                sel_b    = cmd_b[i*FLOAT_W +: FLOAT_W];
                sel_c    = chan_c[i*FLOAT_W +: FLOAT_W];
                sel_mode = cmd_mode[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_valid <= 1'b0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_c     <= '0;
            fpu_mode  <= '0;
            fpu_tag   <= '0;
            rr_ptr    <= TAG_W'(CHANNELS - 1);
        end else begin
            fpu_valid <= grant_any;
            if (grant_any) begin
                fpu_a    <= sel_a;
                fpu_b    <= sel_b;
                fpu_c    <= sel_c;
                fpu_mode <= sel_mode;
                fpu_tag  <= grant_idx;
                rr_ptr   <= grant_idx;
            end
        end
    end

    // Shadow of the FMA pipeline: tells us which channel owns each returning result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_valid[0] <= fpu_valid;
            pipe_tag[0]   <= fpu_tag;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (fpu_result_valid != exp_valid) begin
            error <= 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0]   inflight;
        logic [CNT_W-1:0]   count;
        logic [CNT_W:0]     used;
        logic [FLOAT_W-1:0] acc;
        logic [PTR_W-1:0]   rd_ptr;
        logic [PTR_W-1:0]   wr_ptr;
        logic [FLOAT_W-1:0] mem [OUT_DEPTH];
        logic               push;
        logic               pop;

        // Credits cover both results in flight and results parked in the FIFO,
        // so a push can never find the FIFO full.
        assign used        = (CNT_W+1)'(inflight) + (CNT_W+1)'(count);
        assign eligible[g] = cmd_valid[g] && (used < (CNT_W+1)'(OUT_DEPTH)) &&
                             (!cmd_use_acc[g] || inflight == '0);
        assign chan_c[g*FLOAT_W +: FLOAT_W] = cmd_use_acc[g] ? acc : cmd_c[g*FLOAT_W +: FLOAT_W];

        assign push         = ret && (exp_tag == TAG_W'(g));
        assign res_valid[g] = (count != '0);
        assign pop          = res_valid[g] && res_ready[g];
        assign res_data[g*FLOAT_W +: FLOAT_W] = mem[rd_ptr];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inflight <= '0;
                count    <= '0;
                acc      <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                case ({grant[g], push})
                    2'b10:   inflight <= inflight + CNT_W'(1);
                    2'b01:   inflight <= inflight - CNT_W'(1);
                    default: inflight <= inflight;
                endcase
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                if (push) begin
                    acc    <= fpu_result;
                    wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= fpu_result;
        end
    end

endmodule
